// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; DATA_WIDTH steps per op.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_flush,
    input  logic                  i_hi_we,
    input  logic                  i_lo_we,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [2*W-1:0]       r_acc;
    logic [W-1:0]         r_opd;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div_zero;
    logic [W-1:0]         r_hi;
    logic [W-1:0]         r_lo;
    logic                 r_done;

    logic                 w_signed;
    logic                 w_is_div;
    logic                 w_accept;
    logic [W-1:0]         w_abs_a;
    logic [W-1:0]         w_abs_b;

    logic [W:0]           w_mul_sum;
    logic [2*W-1:0]       w_mul_next;
    logic [W:0]           w_div_shift;
    logic [W:0]           w_div_diff;
    logic [2*W-1:0]       w_div_next;
    logic [2*W-1:0]       w_step;

    logic [2*W-1:0]       w_prod_neg;
    logic [W-1:0]         w_quo_neg;
    logic [W-1:0]         w_rem_neg;
    logic [W-1:0]         w_fix_hi;
    logic [W-1:0]         w_fix_lo;

    // op[0]=0 selects the signed variant, op[1]=1 selects divide
    assign w_signed = ~i_op[0];
    assign w_is_div = i_op[1];
    assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;
    assign w_abs_a  = (w_signed && i_a[W-1]) ? ('0 - i_a) : i_a;
    assign w_abs_b  = (w_signed && i_b[W-1]) ? ('0 - i_b) : i_b;

    // Multiply: r_acc holds {partial product, remaining multiplier bits}, r_opd the multiplicand
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Divide: r_acc holds {remainder, dividend/quotient}, r_opd the divisor
    assign w_div_shift = r_acc[2*W-1:W-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opd};
    assign w_div_next  = w_div_diff[W] ? {w_div_shift[W-1:0], r_acc[W-2:0], 1'b0}
                                       : {w_div_diff[W-1:0],  r_acc[W-2:0], 1'b1};

    assign w_step = r_is_div ? w_div_next : w_mul_next;

    assign w_prod_neg = '0 - r_acc;
    assign w_quo_neg  = '0 - r_acc[W-1:0];
    assign w_rem_neg  = '0 - r_acc[2*W-1:W];

    always_comb begin
        w_fix_hi = r_acc[2*W-1:W];
        w_fix_lo = r_acc[W-1:0];
        if (!r_is_div) begin
            if (r_neg_q) begin
                w_fix_hi = w_prod_neg[2*W-1:W];
                w_fix_lo = w_prod_neg[W-1:0];
            end
        end else begin
            // The divide-by-zero remainder equals the dividend magnitude, so
            // restoring the dividend sign reproduces the original a
            if (r_neg_r) begin
                w_fix_hi = w_rem_neg;
            end
            if (r_div_zero) begin
                w_fix_lo = '1;
            end else if (r_neg_q) begin
                w_fix_lo = w_quo_neg;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (i_flush) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == CNT_WIDTH'(W - 1)) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc      <= '0;
            r_opd      <= '0;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_div   <= w_is_div;
                        r_neg_q    <= w_signed && (i_a[W-1] ^ i_b[W-1]);
                        r_neg_r    <= w_signed && i_a[W-1];
                        r_div_zero <= w_is_div && (i_b == '0);
                        r_cnt      <= '0;
                        if (w_is_div) begin
                            r_acc <= {{W{1'b0}}, w_abs_a};
                            r_opd <= w_abs_b;
                        end else begin
                            r_acc <= {{W{1'b0}}, w_abs_b};
                            r_opd <= w_abs_a;
                        end
                    end
                    if (i_hi_we) begin
                        r_hi <= i_wdata;
                    end
                    if (i_lo_we) begin
                        r_lo <= i_wdata;
                    end
                end
                S_RUN: begin
                    if (!i_flush) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                S_FIX: begin
                    if (!i_flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed plan steps plus randomized
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hiWe;
    logic        loWe;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int passCount  = 0;
    int totalCount = 0;

    mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .i_flush (flush),
        .i_hi_we (hiWe),
        .i_lo_we (loWe),
        .i_wdata (wdata),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Reference result {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] refModel(input logic [1:0] rop, input logic [31:0] ra, input logic [31:0] rb);
        longint sa = longint'($signed(ra));
        longint sb = longint'($signed(rb));
        longint unsigned ua = {32'b0, ra};
        longint unsigned ub = {32'b0, rb};
        longint q;
        longint r;
        longint unsigned p;
        case (rop)
            2'b00: begin
                q = sa * sb;
                return q;
            end
            2'b01: begin
                p = ua * ub;
                return p;
            end
            default: begin
                if (rb == 32'h0) return {ra, 32'hFFFFFFFF};
                if (rop == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Present an operation in the current cycle, then scramble the operand inputs
    task automatic applyStimulus(input logic [1:0] sop, input logic [31:0] sa, input logic [31:0] sb);
        op    = sop;
        a     = sa;
        b     = sb;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Start in cycle T, expect busy through T+33 and the result with done in T+34
    task automatic runOp(input string tag, input logic [1:0] rop, input logic [31:0] ra,
                         input logic [31:0] rb, input logic [31:0] expHi, input logic [31:0] expLo);
        int badCycles = 0;
        applyStimulus(rop, ra, rb);
        for (int c = 1; c <= 33; c++) begin
            if (!(busy === 1'b1 && done === 1'b0)) badCycles++;
            tick();
        end
        checkOutput({tag, "_busyWindow"}, badCycles, 0);
        checkOutput({tag, "_done"}, {31'b0, done}, 1);
        checkOutput({tag, "_busyLow"}, {31'b0, busy}, 0);
        checkOutput({tag, "_hi"}, hi, expHi);
        checkOutput({tag, "_lo"}, lo, expLo);
    endtask

    initial begin
        logic [63:0] exp;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          bad;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        hiWe  = 1'b0;
        loWe  = 1'b0;
        wdata = '0;
        tickN(2);
        checkOutput("reset_busy", {31'b0, busy}, 0);
        checkOutput("reset_done", {31'b0, done}, 0);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        reset = 1'b0;
        tick();

        $display("[TB] multiply cases");
        runOp("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        runOp("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        runOp("multu_b2b", 2'b01, 32'd3, 32'd5, 32'h0, 32'hF);

        $display("[TB] divide cases");
        runOp("div_m7by2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("divu_7by2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
        runOp("div_7bym2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        runOp("divu_by0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        runOp("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        runOp("div_neg_by0", 2'b10, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF);
        tick();
        checkOutput("done_one_cycle", {31'b0, done}, 0);

        $display("[TB] flush and ignored start");
        hiWe  = 1'b1;
        wdata = 32'h1234;
        tick();
        hiWe  = 1'b0;
        loWe  = 1'b1;
        wdata = 32'h5678;
        tick();
        loWe  = 1'b0;
        checkOutput("mthi", hi, 32'h1234);
        checkOutput("mtlo", lo, 32'h5678);
        applyStimulus(2'b00, 32'd2, 32'd2);
        tickN(4);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd9;
        b     = 32'd9;
        tick();
        start = 1'b0;
        tickN(4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_busy", {31'b0, busy}, 0);
        checkOutput("flush_done", {31'b0, done}, 0);
        checkOutput("flush_hi", hi, 32'h1234);
        checkOutput("flush_lo", lo, 32'h5678);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678) bad++;
        end
        checkOutput("flush_quiet", bad, 0);

        $display("[TB] blocked write and reset");
        applyStimulus(2'b00, 32'd3, 32'd3);
        tickN(2);
        hiWe  = 1'b1;
        wdata = 32'hDEAD;
        tick();
        hiWe  = 1'b0;
        checkOutput("busy_mthi_blocked", hi, 32'h1234);
        tickN(16);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_busy", {31'b0, busy}, 0);
        checkOutput("midreset_done", {31'b0, done}, 0);
        checkOutput("midreset_hi", hi, 0);
        checkOutput("midreset_lo", lo, 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checkOutput("midreset_quiet", bad, 0);
        runOp("after_reset", 2'b00, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6);
        tick();

        $display("[TB] write with start in the same cycle");
        hiWe  = 1'b1;
        loWe  = 1'b1;
        wdata = 32'hCAFEF00D;
        op    = 2'b01;
        a     = 32'd6;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        hiWe  = 1'b0;
        loWe  = 1'b0;
        checkOutput("same_cycle_hi", hi, 32'hCAFEF00D);
        checkOutput("same_cycle_lo", lo, 32'hCAFEF00D);
        tickN(33);
        checkOutput("same_cycle_done", {31'b0, done}, 1);
        checkOutput("same_cycle_res_hi", hi, 32'h0);
        checkOutput("same_cycle_res_lo", lo, 32'd42);

        $display("[TB] randomized operations");
        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = $urandom_range(1, 15);
                2: begin
                    ra = 32'h80000000;
                    rb = 32'hFFFFFFFF;
                end
                3: ra = $urandom_range(0, 255);
                default: ;
            endcase
            exp = refModel(rop, ra, rb);
            runOp($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, exp[63:32], exp[31:0]);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage. It executes MULT, MULTU, DIV and DIVU and owns the architectural HI/LO registers.
- The EX stage initiates each operation with a start/busy/done handshake. The hazard unit stalls on busy.
- It complements the single-cycle combinational ALU: it covers the multi-cycle arithmetic the ALU does not implement.
- It also serves MTHI/MTLO writes and MFHI/MFLO reads through the hi/lo outputs.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a  input  DATA_WIDTH  rs operand (multiplicand/dividend).
- b  input  DATA_WIDTH  rt operand (multiplier/divisor).
- flush  input  1  abort in-flight operation (branch/exception squash).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  DATA_WIDTH  MTHI/MTLO data.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  DATA_WIDTH  HI register.
- lo  output  DATA_WIDTH  LO register.

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (reset).
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Reset priority: reset > flush > start/hi_we/lo_we.

State machine:
- IDLE: start=1 latches op, the absolute values of a/b (signed ops) or raw a/b (unsigned ops), and the result sign flags; counter=0; go to RUN.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*DATA_WIDTH accumulator.
  - Divide: restoring step on a remainder/quotient pair.
  - After DATA_WIDTH steps, go to FIX.
- FIX: apply sign correction and write HI/LO. Go to IDLE and register done=1.
  - Multiply: {hi,lo}=64-bit product, negated if the operand signs differ (signed op).
  - Divide: lo=quotient, hi=remainder. The quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.

Timing:
- Start high in cycle T (IDLE) gives busy=1 in cycles T+1..T+33.
- In cycle T+34: busy=0, done=1, and hi/lo hold the new result.
- A new start in T+34 is accepted (back-to-back operations allowed).
- busy is the registered "state != IDLE"; done is high for exactly one cycle.

Boundary cases:
- start while busy: ignored; no queueing.
- Divide by zero (b=0), DIV or DIVU: lo=all-ones, hi=a unmodified, same latency.
- DIV of most-negative by -1: lo=0x80000000, hi=0 (wraps, no trap).
- flush while busy: next cycle state=IDLE, busy=0, no done pulse, hi/lo unchanged.
- flush in IDLE: no effect, except that it blocks a start in the same cycle.
- hi_we/lo_we in IDLE: the register takes wdata at the next edge.
- hi_we/lo_we while busy: ignored.
- hi_we/lo_we with start in the same IDLE cycle: the write takes effect, and the operation later overwrites both registers at FIX.
- Both hi_we and lo_we high: both registers are written.
- reset mid-operation: all outputs return to their reset values at the next edge; no done pulse.
- op/a/b changes after the start cycle: no effect on the result (operands are captured).
- hi/lo change only at FIX, on MTHI/MTLO, or on reset.

Test Plan:
1. MULT a=0xFFFFFFFD (-3), b=7, start in cycle T -> busy T+1..T+33; in T+34 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
   - Then a back-to-back start in the done cycle, MULTU 3*5 -> hi=0, lo=0xF, 34 cycles later.
3. Division results:
   - DIV -7/2 (a=0xFFFFFFF9, b=2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU 7/2 -> lo=3, hi=1.
   - DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
4. Division corner cases:
   - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
   - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
   - Both complete at T+34.
5. Flush and ignored start:
   - Preload MTHI 0x1234 and MTLO 0x5678.
   - Start MULT 2*2, then flush in T+10 -> busy=0 in T+11, no done, hi=0x1234, lo=0x5678.
   - start pulsed in T+5 during busy is ignored.
6. Reset and blocked writes:
   - hi_we while busy -> hi unchanged.
   - reset in T+20 -> busy=0, done=0, hi=lo=0 in T+21; no done pulse ever.
   - A start after reset works normally.
